// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_pkg
//  Description : Shared types and constants for the ALU operand stage.
//                - alu_fn_t : ALU function, encoded exactly as RV32I funct3.
//                - funct7_t : ADD/SRL versus SUB/SRA select.
//                - state_t  : output register occupancy (EMPTY / FULL).
//                - opcode and raw funct7 constants used by the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_stage_pkg;

   typedef enum logic [2:0] {
      ADD_SUB = 3'd0,
      SLL     = 3'd1,
      SLT     = 3'd2,
      SLTU    = 3'd3,
      XOR     = 3'd4,
      SRL_SRA = 3'd5,
      OR      = 3'd6,
      AND     = 3'd7
   } alu_fn_t;

   typedef enum logic {
      ADD_SRL = 1'b0,
      SUB_SRA = 1'b1
   } funct7_t;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'h00;
   localparam logic [6:0] F7_ALT     = 7'h20;

   // Shift functions take a 5-bit shamt instead of a 12-bit immediate.
   function automatic logic is_shift(input alu_fn_t fn);
      return (fn == SLL) || (fn == SRL_SRA);
   endfunction

endpackage : alu_operand_stage_pkg
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : Bundle of the operand stage's data-path signals.
//                Instruction side : in_valid, in_ready, instr
//                Writeback side   : wb_en, wb_rd, wb_data
//                ALU side         : out_valid, out_ready, fn, funct7, a, b,
//                                   rd, illegal
//                Modports: slave  = the operand stage itself
//                          master = the surrounding pipeline / environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if
   import alu_operand_stage_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;

   logic             wb_en;
   logic [4:0]       wb_rd;
   logic [WIDTH-1:0] wb_data;

   logic             out_valid;
   logic             out_ready;
   alu_fn_t          fn;
   funct7_t          funct7;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       rd;
   logic             illegal;

   modport slave (
      input  in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, fn, funct7, a, b, rd, illegal
   );

   modport master (
      output in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, fn, funct7, a, b, rd, illegal
   );

endinterface : alu_operand_stage_if
`default_nettype wire

// File: rtl/alu_operand_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_reg_file
//  Description : NUM_REGS x WIDTH architectural register file.
//                Two asynchronous read ports, one synchronous write port,
//                asynchronous active-low reset clearing every register.
//                x0 always reads zero and ignores writes. A read of the
//                register being written in the same cycle returns wb_data.
//  Ports       : clk, rst_n            clock / async active-low reset
//                wb_en, wb_rd, wb_data write port
//                rs1_idx, rs1_data     read port 1
//                rs2_idx, rs2_data     read port 2
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage_reg_file #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             wb_en,
   input  wire logic [IDX_W-1:0] wb_rd,
   input  wire logic [WIDTH-1:0] wb_data,
   input  wire logic [IDX_W-1:0] rs1_idx,
   input  wire logic [IDX_W-1:0] rs2_idx,
   output logic      [WIDTH-1:0] rs1_data,
   output logic      [WIDTH-1:0] rs2_data
);

   logic [WIDTH-1:0] r_regs [NUM_REGS];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wb_en && (wb_rd != '0)) begin
         r_regs[wb_rd] <= wb_data;
      end
   end

   // Bypass lets an instruction accepted in the writeback cycle see the new value.
   always_comb begin
      rs1_data = r_regs[rs1_idx];
      if (rs1_idx == '0) begin
         rs1_data = '0;
      end else if (wb_en && (wb_rd == rs1_idx)) begin
         rs1_data = wb_data;
      end
   end

   always_comb begin
      rs2_data = r_regs[rs2_idx];
      if (rs2_idx == '0) begin
         rs2_data = '0;
      end else if (wb_en && (wb_rd == rs2_idx)) begin
         rs2_data = wb_data;
      end
   end

endmodule : alu_operand_stage_reg_file
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Decode / register-read stage feeding the ALU. Accepts one
//                RV32I instruction per valid/ready handshake, decodes OP and
//                OP-IMM integer operations, reads rs1/rs2 from the internal
//                register file and registers fn/funct7/a/b/rd/illegal in a
//                single output slot with valid/ready flow control.
//  Ports       : clk    clock, all state on posedge
//                rst_n  asynchronous active-low reset
//                bus    alu_operand_stage_if.slave (instruction, writeback
//                       and ALU-side signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 32
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   alu_operand_stage_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_REGS);

   // ------------------------------------------------------------------
   // Instruction fields
   // ------------------------------------------------------------------
   logic [6:0]       w_opcode;
   logic [4:0]       w_rd_field;
   alu_fn_t          w_funct3;
   logic [6:0]       w_f7_raw;
   logic [IDX_W-1:0] w_rs1_idx;
   logic [IDX_W-1:0] w_rs2_idx;

   assign w_opcode   = bus.instr[6:0];
   assign w_rd_field = bus.instr[11:7];
   assign w_funct3   = alu_fn_t'(bus.instr[14:12]);
   assign w_f7_raw   = bus.instr[31:25];
   assign w_rs1_idx  = bus.instr[15 +: IDX_W];
   assign w_rs2_idx  = bus.instr[20 +: IDX_W];

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_rs1_data;
   logic [WIDTH-1:0] w_rs2_data;

   alu_operand_stage_reg_file #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_reg_file (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_en    (bus.wb_en),
      .wb_rd    (bus.wb_rd[IDX_W-1:0]),
      .wb_data  (bus.wb_data),
      .rs1_idx  (w_rs1_idx),
      .rs2_idx  (w_rs2_idx),
      .rs1_data (w_rs1_data),
      .rs2_data (w_rs2_data)
   );

   // ------------------------------------------------------------------
   // Decoder: illegal instructions fall through with all-zero payload
   // ------------------------------------------------------------------
   logic             w_legal;
   alu_fn_t          w_fn;
   funct7_t          w_funct7;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [4:0]       w_rd;

   always_comb begin
      w_legal  = 1'b0;
      w_fn     = ADD_SUB;
      w_funct7 = ADD_SRL;
      w_a      = '0;
      w_b      = '0;
      w_rd     = '0;
      case (w_opcode)
         OPC_OP: begin
            if (w_f7_raw == F7_ZERO) begin
               w_legal = 1'b1;
            end else if ((w_f7_raw == F7_ALT) &&
                         ((w_funct3 == ADD_SUB) || (w_funct3 == SRL_SRA))) begin
               w_legal  = 1'b1;
               w_funct7 = SUB_SRA;
            end
            if (w_legal) begin
               w_fn = w_funct3;
               w_a  = w_rs1_data;
               w_b  = w_rs2_data;
               w_rd = w_rd_field;
            end
         end
         OPC_OP_IMM: begin
            if (is_shift(w_funct3)) begin
               // imm[11:5] doubles as funct7; only SRAI may set the alternate bit.
               if (w_f7_raw == F7_ZERO) begin
                  w_legal = 1'b1;
               end else if ((w_f7_raw == F7_ALT) && (w_funct3 == SRL_SRA)) begin
                  w_legal  = 1'b1;
                  w_funct7 = SUB_SRA;
               end
               w_b = {{(WIDTH-5){1'b0}}, bus.instr[24:20]};
            end else begin
               w_legal = 1'b1;
               w_b     = {{(WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
            end
            if (w_legal) begin
               w_fn = w_funct3;
               w_a  = w_rs1_data;
               w_rd = w_rd_field;
            end else begin
               w_funct7 = ADD_SRL;
               w_b      = '0;
            end
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output slot FSM
   // ------------------------------------------------------------------
   state_t r_state;
   state_t w_state_nxt;
   logic   w_out_valid;
   logic   w_in_ready;
   logic   w_accept;

   assign w_out_valid = (r_state == ST_FULL);
   assign w_in_ready  = !w_out_valid || bus.out_ready;
   assign w_accept    = bus.in_valid && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A consumed slot refilled in the same cycle stays FULL (no bubble).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (bus.out_ready && !bus.in_valid) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output payload register, loaded only on accept
   // ------------------------------------------------------------------
   alu_fn_t          r_fn;
   funct7_t          r_funct7;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [4:0]       r_rd;
   logic             r_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fn      <= ADD_SUB;
         r_funct7  <= ADD_SRL;
         r_a       <= '0;
         r_b       <= '0;
         r_rd      <= '0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_fn      <= w_fn;
         r_funct7  <= w_funct7;
         r_a       <= w_a;
         r_b       <= w_b;
         r_rd      <= w_rd;
         r_illegal <= !w_legal;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.fn        = r_fn;
   assign bus.funct7    = r_funct7;
   assign bus.a         = r_a;
   assign bus.b         = r_b;
   assign bus.rd        = r_rd;
   assign bus.illegal   = r_illegal;

endmodule : alu_operand_stage
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage. Expected ALU
//                operands are queued when an instruction is accepted and
//                compared when the stage presents them to the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   typedef struct {
      string       tag;
      logic [2:0]  fn;
      logic        f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_operand_stage_if #(.WIDTH(32)) bus ();

   alu_operand_stage #(
      .WIDTH    (32),
      .NUM_REGS (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t mk(input string tag, input logic [2:0] fn, input logic f7,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic ill);
      exp_t e;
      e.tag = tag; e.fn = fn; e.f7 = f7; e.a = a; e.b = b; e.rd = rd; e.ill = ill;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         check("unexpected_output_queue_size", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, ".fn"},      32'(bus.fn),      32'(e.fn));
         check({e.tag, ".funct7"},  32'(bus.funct7),  32'(e.f7));
         check({e.tag, ".a"},       bus.a,            e.a);
         check({e.tag, ".b"},       bus.b,            e.b);
         check({e.tag, ".rd"},      32'(bus.rd),      32'(e.rd));
         check({e.tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
      end
   endtask

   // One cycle: drive inputs just after negedge, sample mid-low-phase,
   // then the posedge acts on what was driven.
   task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input exp_t e);
      bus.in_valid  = iv;
      bus.instr     = ins;
      bus.out_ready = ordy;
      bus.wb_en     = we;
      bus.wb_rd     = wrd;
      bus.wb_data   = wd;
      #1;
      if (bus.out_valid && bus.out_ready) compare_out();
      if (iv && bus.in_ready) sb.push_back(e);
      @(negedge clk);
   endtask

   exp_t none;

   task automatic send(input logic [31:0] ins, input exp_t e);
      step(1'b1, ins, 1'b1, 1'b0, 5'd0, 32'd0, e);
   endtask

   task automatic wb(input logic [4:0] wrd, input logic [31:0] wd);
      step(1'b0, 32'd0, 1'b1, 1'b1, wrd, wd, none);
   endtask

   task automatic drain();
      for (int k = 0; k < 8 && sb.size() != 0; k++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, none);
      end
      check("drain_queue_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      none = mk("none", 3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      bus.in_valid  = 1'b0;
      bus.instr     = 32'd0;
      bus.out_ready = 1'b1;
      bus.wb_en     = 1'b0;
      bus.wb_rd     = 5'd0;
      bus.wb_data   = 32'd0;

      // 1: reset held low for three cycles
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset.out_valid", 32'(bus.out_valid), 32'd0);
      check("reset.in_ready",  32'(bus.in_ready),  32'd1);
      check("reset.a",         bus.a,              32'd0);
      check("reset.b",         bus.b,              32'd0);
      check("reset.fn",        32'(bus.fn),        32'(ADD_SUB));
      check("reset.funct7",    32'(bus.funct7),    32'(ADD_SRL));
      check("reset.rd",        32'(bus.rd),        32'd0);
      check("reset.illegal",   32'(bus.illegal),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // every register reads zero after reset (back-to-back ADDs)
      for (int i = 1; i < 32; i += 2) begin
         ins = {7'h00, 5'((i + 1) % 32), 5'(i), 3'b000, 5'(i), 7'b0110011};
         send(ins, mk($sformatf("zero_x%0d", i), 3'd0, 1'b0, 32'd0, 32'd0, 5'(i), 1'b0));
      end

      // 2: writeback then R-type
      wb(5'd1, 32'd5);
      wb(5'd2, 32'd6);
      send(32'h002081B3, mk("add",  3'd0, 1'b0, 32'd5, 32'd6, 5'd3, 1'b0));
      send(32'h402081B3, mk("sub",  3'd0, 1'b1, 32'd5, 32'd6, 5'd3, 1'b0));

      // 3: immediates
      send(32'hFFB00213, mk("addi", 3'd0, 1'b0, 32'd0, 32'hFFFFFFFB, 5'd4, 1'b0));
      send(32'h4030D293, mk("srai", 3'd5, 1'b1, 32'd5, 32'd3, 5'd5, 1'b0));
      send(32'h7FF17393, mk("andi", 3'd7, 1'b0, 32'd6, 32'h000007FF, 5'd7, 1'b0));
      drain();

      // 4: backpressure for three cycles, then consume and reload together
      send(32'h00114333, mk("xor", 3'd4, 1'b0, 32'd6, 32'd5, 5'd6, 1'b0));
      for (int k = 0; k < 3; k++) begin
         bus.in_valid  = 1'b1;
         bus.instr     = 32'h7FF17393;
         bus.out_ready = 1'b0;
         #1;
         check($sformatf("stall%0d.in_ready", k),  32'(bus.in_ready),  32'd0);
         check($sformatf("stall%0d.out_valid", k), 32'(bus.out_valid), 32'd1);
         check($sformatf("stall%0d.a", k),         bus.a,              32'd6);
         check($sformatf("stall%0d.b", k),         bus.b,              32'd5);
         check($sformatf("stall%0d.fn", k),        32'(bus.fn),        32'(XOR));
         @(negedge clk);
      end
      send(32'h7FF17393, mk("andi_reload", 3'd7, 1'b0, 32'd6, 32'h000007FF, 5'd7, 1'b0));
      check("reload.no_bubble", 32'(bus.out_valid), 32'd1);
      drain();

      // 5: read-during-write bypass and x0 write protection
      step(1'b1, 32'h002081B3, 1'b1, 1'b1, 5'd1, 32'hDEADBEEF,
           mk("bypass_x1", 3'd0, 1'b0, 32'hDEADBEEF, 32'd6, 5'd3, 1'b0));
      wb(5'd0, 32'h00001234);
      send(32'h000001B3, mk("x0_after_write", 3'd0, 1'b0, 32'd0, 32'd0, 5'd3, 1'b0));
      step(1'b1, 32'h000001B3, 1'b1, 1'b1, 5'd0, 32'h00005555,
           mk("x0_no_bypass", 3'd0, 1'b0, 32'd0, 32'd0, 5'd3, 1'b0));
      send(32'h002081B3, mk("x1_stored", 3'd0, 1'b0, 32'hDEADBEEF, 32'd6, 5'd3, 1'b0));

      // 6: illegal encodings
      send(32'h0000007F, mk("ill_opcode",   3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1));
      send(32'h802081B3, mk("ill_funct7",   3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1));
      send(32'h40109193, mk("ill_slli_alt", 3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1));
      send(32'h4020E1B3, mk("ill_or_alt",   3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1));
      send(32'h00114333, mk("xor_after_ill", 3'd4, 1'b0, 32'd6, 32'hDEADBEEF, 5'd6, 1'b0));
      drain();

      // reset while FULL discards the held output and clears registers
      send(32'h002081B3, mk("add_discarded", 3'd0, 1'b0, 32'hDEADBEEF, 32'd6, 5'd3, 1'b0));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("pre_reset.out_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset.out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_reset.a",         bus.a,              32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(32'h002081B3, mk("add_after_reset", 3'd0, 1'b0, 32'd0, 32'd0, 5'd3, 1'b0));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu_operand_stage
`default_nettype wire
